// File: rtl/escalonador_som.sv
// Clocked audio-output scheduler for TV, PC and ALEXA: fixed priority ALEXA > PC > TV,
// minimum hold per grant, and a muted gap of GAP cycles on every source change.
module escalonador_som #(
  parameter int MIN_HOLD = 4,
  parameter int GAP      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_tv,
  input  logic       req_pc,
  input  logic       req_alexa,
  output logic       TV,
  output logic       PC,
  output logic       ALEXA,
  output logic       mute,
  output logic [1:0] src
);

  localparam logic [7:0] HOLD_MAX = 8'(MIN_HOLD);
  localparam logic [7:0] GAP_LOAD = 8'(GAP - 1);

  // Source codes double as priority ranks: a larger code always wins.
  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_TV    = 2'b01;
  localparam logic [1:0] SRC_PC    = 2'b10;
  localparam logic [1:0] SRC_ALEXA = 2'b11;

  typedef enum logic [1:0] {IDLE, GRANT, SWITCH} state_t;

  state_t     state_reg;
  logic [7:0] hold_cnt_reg;
  logic [7:0] gap_cnt_reg;

  logic [1:0] winner;
  logic       any_req;
  logic       cur_req;
  logic       eligible;
  logic       preempt;
  logic       leave;

  always_comb begin
    winner = SRC_NONE;
    if (req_alexa)   winner = SRC_ALEXA;
    else if (req_pc) winner = SRC_PC;
    else if (req_tv) winner = SRC_TV;
  end

  always_comb begin
    cur_req = 1'b0;
    case (src)
      SRC_TV:    cur_req = req_tv;
      SRC_PC:    cur_req = req_pc;
      SRC_ALEXA: cur_req = req_alexa;
      default:   cur_req = 1'b0;
    endcase
  end

  assign any_req  = req_tv | req_pc | req_alexa;
  assign eligible = (hold_cnt_reg == HOLD_MAX);
  assign preempt  = req_alexa && (src != SRC_ALEXA);
  assign leave    = preempt || (eligible && ((winner > src) || !cur_req));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= 8'd0;
      gap_cnt_reg  <= 8'd0;
      src          <= SRC_NONE;
      TV           <= 1'b0;
      PC           <= 1'b0;
      ALEXA        <= 1'b0;
      mute         <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            state_reg    <= GRANT;
            hold_cnt_reg <= 8'd1;
            src          <= winner;
            TV           <= (winner == SRC_TV);
            PC           <= (winner == SRC_PC);
            ALEXA        <= (winner == SRC_ALEXA);
            mute         <= 1'b0;
          end
        end
        GRANT: begin
          if (leave) begin
            state_reg   <= SWITCH;
            gap_cnt_reg <= GAP_LOAD;
            src         <= SRC_NONE;
            TV          <= 1'b0;
            PC          <= 1'b0;
            ALEXA       <= 1'b0;
            mute        <= 1'b1;
          end else if (!eligible) begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        SWITCH: begin
          // Requests are sampled live on the last gap edge, not latched at switch time.
          if (gap_cnt_reg == 8'd0) begin
            if (any_req) begin
              state_reg    <= GRANT;
              hold_cnt_reg <= 8'd1;
              src          <= winner;
              TV           <= (winner == SRC_TV);
              PC           <= (winner == SRC_PC);
              ALEXA        <= (winner == SRC_ALEXA);
              mute         <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_som.sv
// Bench for escalonador_som: cycle-count reference model checked every cycle, plus
// directed scenarios with literal expectations and a random exclusivity run.
module tb_escalonador_som;

  localparam int MIN_HOLD = 4;
  localparam int GAP      = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_tv = 1'b0;
  logic       req_pc = 1'b0;
  logic       req_alexa = 1'b0;
  logic       TV, PC, ALEXA, mute;
  logic [1:0] src;

  int tests_run = 0;
  int tests_failed = 0;

  escalonador_som #(.MIN_HOLD(MIN_HOLD), .GAP(GAP)) dut (
    .clk(clk), .rst(rst),
    .req_tv(req_tv), .req_pc(req_pc), .req_alexa(req_alexa),
    .TV(TV), .PC(PC), .ALEXA(ALEXA), .mute(mute), .src(src)
  );

  always #5 clk = ~clk;

  // Reference model: owner of the output (0 none, 1 TV, 2 PC, 3 ALEXA), cycles it has
  // been granted, and muted cycles already spent in the current gap.
  int m_cur = 0;
  int m_held = 0;
  int m_gap_done = 0;
  bit m_in_gap = 1'b0;
  int m_win;
  bit m_cur_req;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cur = 0; m_held = 0; m_gap_done = 0; m_in_gap = 1'b0;
    end else begin
      m_win = req_alexa ? 3 : (req_pc ? 2 : (req_tv ? 1 : 0));
      m_cur_req = (m_cur == 1 && req_tv) || (m_cur == 2 && req_pc) || (m_cur == 3 && req_alexa);
      if (m_in_gap) begin
        m_gap_done = m_gap_done + 1;
        if (m_gap_done == GAP) begin
          m_in_gap = 1'b0;
          m_cur = m_win;
          m_held = 1;
        end
      end else if (m_cur == 0) begin
        if (m_win != 0) begin
          m_cur = m_win;
          m_held = 1;
        end
      end else if ((req_alexa && m_cur != 3) ||
                   (m_held >= MIN_HOLD && (m_win > m_cur || !m_cur_req))) begin
        m_cur = 0;
        m_in_gap = 1'b1;
        m_gap_done = 0;
      end else begin
        m_held = m_held + 1;
      end
    end
  end

  // Single compare process against the model, on the inactive edge.
  always @(negedge clk) begin
    if (!rst) begin
      tests_run = tests_run + 1;
      if (src !== 2'(m_cur) || TV !== (m_cur == 1) || PC !== (m_cur == 2) ||
          ALEXA !== (m_cur == 3) || mute !== (m_cur == 0)) begin
        tests_failed = tests_failed + 1;
        $display("FAIL model t=%0t: got src=%b TV=%b PC=%b ALEXA=%b mute=%b, required src=%0d mute=%0d",
                 $time, src, TV, PC, ALEXA, mute, m_cur, (m_cur == 0));
      end
      tests_run = tests_run + 1;
      if ((32'(TV) + 32'(PC) + 32'(ALEXA)) > 1) begin
        tests_failed = tests_failed + 1;
        $display("FAIL exclusive t=%0t: got TV=%b PC=%b ALEXA=%b, required at most one high",
                 $time, TV, PC, ALEXA);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input bit t, input bit p, input bit a);
    req_tv = t; req_pc = p; req_alexa = a;
  endtask

  task automatic expect_src(input string name, input logic [1:0] exp);
    tests_run = tests_run + 1;
    if (src !== exp || mute !== (exp == 2'b00)) begin
      tests_failed = tests_failed + 1;
      $display("FAIL %s: got src=%b mute=%b, required src=%b mute=%b",
               name, src, mute, exp, (exp == 2'b00));
    end else begin
      $display("[TB] %s: src=%b mute=%b", name, src, mute);
    end
  endtask

  task automatic settle_idle();
    set_req(0, 0, 0);
    repeat (10) tick();
  endtask

  initial begin
    // Reset state
    #12;
    expect_src("reset_state", 2'b00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_src("idle_after_reset", 2'b00);

    // Single TV request, dropped after one edge
    set_req(1, 0, 0);
    tick();
    expect_src("tv_grant_e0", 2'b01);
    set_req(0, 0, 0);
    tick(); tick(); tick();
    expect_src("tv_hold_e3", 2'b01);
    tick();
    expect_src("tv_gap_e4", 2'b00);
    tick();
    expect_src("tv_gap_e5", 2'b00);
    tick();
    expect_src("tv_idle_e6", 2'b00);

    // Simultaneous TV+PC: PC wins, held to edge 10, then TV after the gap
    set_req(1, 1, 0);
    tick();
    expect_src("pc_over_tv_e0", 2'b10);
    repeat (9) tick();
    expect_src("pc_held_e9", 2'b10);
    set_req(1, 0, 0);
    tick();
    expect_src("pc_release_gap_e10", 2'b00);
    tick();
    expect_src("pc_release_gap_e11", 2'b00);
    tick();
    expect_src("tv_after_pc_e12", 2'b01);
    settle_idle();

    // ALEXA preempts a fresh PC grant, then PC returns after ALEXA releases
    set_req(0, 1, 0);
    tick();
    expect_src("pc_grant", 2'b10);
    set_req(0, 1, 1);
    tick();
    expect_src("alexa_preempt_gap1", 2'b00);
    tick();
    expect_src("alexa_preempt_gap2", 2'b00);
    tick();
    expect_src("alexa_grant", 2'b11);
    tick(); tick(); tick();
    set_req(0, 1, 0);
    tick();
    expect_src("alexa_release_gap", 2'b00);
    tick();
    tick();
    expect_src("pc_regrant", 2'b10);
    settle_idle();

    // PC arriving during TV's hold waits for eligibility
    set_req(1, 0, 0);
    tick();
    expect_src("tv_grant", 2'b01);
    set_req(1, 1, 0);
    tick(); tick(); tick();
    expect_src("tv_hold_vs_pc", 2'b01);
    tick();
    expect_src("tv_to_pc_gap", 2'b00);
    tick(); tick();
    expect_src("pc_after_hold", 2'b10);

    // Asynchronous reset mid-grant(PC)
    #2;
    rst = 1'b1;
    #1;
    tests_run = tests_run + 1;
    if (TV !== 1'b0 || PC !== 1'b0 || ALEXA !== 1'b0 || mute !== 1'b1 || src !== 2'b00) begin
      tests_failed = tests_failed + 1;
      $display("FAIL async_reset: got TV=%b PC=%b ALEXA=%b mute=%b src=%b, required 0 0 0 1 00",
               TV, PC, ALEXA, mute, src);
    end else begin
      $display("[TB] async_reset: outputs cleared before next edge");
    end
    set_req(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    expect_src("idle_after_async_reset", 2'b00);

    // Random requests; the compare process checks every cycle
    for (int i = 0; i < 1000; i++) begin
      set_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 3) == 0));
      tick();
    end
    $display("[TB] random run: 1000 cycles");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
